// File: rtl/data_mem_master.sv
// data_mem_master: buffers core load/store requests in a small FIFO and sequences them one at a
// time onto a single-port async-read data memory. Define WRITE_VERIFY_EN to read back every store.
module data_mem_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

`ifdef WRITE_VERIFY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2, ST_VERIFY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_t;
`endif

  state_t              state_r;
  logic                fifo_we_r    [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_r  [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_wdata_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W:0]      count_r;
  logic [PTR_W:0]      count_next_s;
  logic                req_ready_r;
  logic                push_s;
  logic                pop_s;
  logic                head_we_s;
  logic [ADDR_W-1:0]   head_addr_s;
  logic [DATA_W-1:0]   head_wdata_s;
  logic [ADDR_W-1:0]   mem_a_r;
  logic [DATA_W-1:0]   mem_wd_r;
  logic                mem_write_r;
  logic                resp_valid_r;
  logic                resp_we_r;
  logic [DATA_W-1:0]   resp_rdata_r;

  assign head_we_s    = fifo_we_r[rd_ptr_r];
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign head_wdata_s = fifo_wdata_r[rd_ptr_r];

  assign req_ready  = req_ready_r;
  assign mem_A      = mem_a_r;
  assign mem_WD     = mem_wd_r;
  assign mem_write  = mem_write_r;
  assign resp_valid = resp_valid_r;
  assign resp_we    = resp_we_r;
  assign resp_rdata = resp_rdata_r;
  assign busy       = (state_r != ST_IDLE) || (count_r != '0);

  // FIFO handshake decode: a pop happens only from IDLE or when the pending response retires.
  always_comb begin
    push_s = req_valid && req_ready_r;
    if (count_r == '0) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: pop_s = 1'b1;
        ST_RESP: pop_s = resp_ready;
        default: pop_s = 1'b0;
      endcase
    end
    count_next_s = count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
  end

  // Request FIFO storage, pointers and registered not-full flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_we_r[i]    <= 1'b0;
        fifo_addr_r[i]  <= '0;
        fifo_wdata_r[i] <= '0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      req_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_we_r[wr_ptr_r]    <= req_we;
        fifo_addr_r[wr_ptr_r]  <= req_addr;
        fifo_wdata_r[wr_ptr_r] <= req_wdata;
        wr_ptr_r               <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= count_next_s;
      req_ready_r <= (count_next_s != FULL_CNT);
    end
  end

`ifdef WRITE_VERIFY_EN
  logic resp_err_r;
  assign resp_err = resp_err_r;
`else
  assign resp_err = 1'b0;
`endif

  // Access sequencer: owns the memory pins and the response channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      mem_a_r      <= '0;
      mem_wd_r     <= '0;
      mem_write_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_we_r    <= 1'b0;
      resp_rdata_r <= '0;
`ifdef WRITE_VERIFY_EN
      resp_err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            mem_a_r     <= head_addr_s;
            mem_wd_r    <= head_we_s ? head_wdata_s : '0;
            mem_write_r <= head_we_s;
            state_r     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // mem_write_r is high in ACCESS exactly when the access is a store
          mem_write_r <= 1'b0;
          resp_we_r   <= mem_write_r;
          if (mem_write_r) begin
            resp_rdata_r <= '0;
`ifdef WRITE_VERIFY_EN
            state_r      <= ST_VERIFY;
`else
            resp_valid_r <= 1'b1;
            state_r      <= ST_RESP;
`endif
          end else begin
            resp_rdata_r <= mem_out;
            resp_valid_r <= 1'b1;
            state_r      <= ST_RESP;
`ifdef WRITE_VERIFY_EN
            resp_err_r   <= 1'b0;
`endif
          end
        end
`ifdef WRITE_VERIFY_EN
        ST_VERIFY: begin
          resp_err_r   <= (mem_out != mem_wd_r);
          resp_valid_r <= 1'b1;
          state_r      <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            if (pop_s) begin
              mem_a_r     <= head_addr_s;
              mem_wd_r    <= head_we_s ? head_wdata_s : '0;
              mem_write_r <= head_we_s;
              state_r     <= ST_ACCESS;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          mem_write_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// Scoreboard bench for data_mem_master: a memory model, a request-level reference model and a
// decoupled monitor that checks responses, response hold and store pin activity.
module tb_data_mem_master;

`ifdef WRITE_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif
  localparam int RESP_LAT = VERIFY_ON ? 4 : 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_ready, resp_we, resp_err;
  logic [7:0] resp_rdata;
  logic [7:0] mem_A, mem_WD, mem_out;
  logic       mem_write, busy;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [9:0] exp_q [$];
  logic [15:0] acc_q [$];
  logic       sync_req, stuck, rr_mode, rr_fixed;
  logic       hold_v = 1'b0, last_mw = 1'b0;
  logic [9:0] hold_val = 10'd0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  data_mem_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_write(mem_write), .mem_out(mem_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] seed(input int i);
    if (i == 0) return 8'h7E;
    else return 8'(i * 37 + 5);
  endfunction

  // Value a store leaves in the memory (bit0 stuck-at-0 when the fault is enabled)
  function automatic logic [7:0] stored_val(input logic [7:0] d);
    return stuck ? (d & 8'hFE) : d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory model: async read, write on the clock edge where mem_write is high
  assign mem_out = mem[mem_A];
  always @(posedge clk) begin
    if (sync_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (mem_write) begin
      mem[mem_A] <= stored_val(mem_WD);
    end
  end

  // Response-ready driver: fixed level or random stalls
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rr_fixed;
    end
  end

  // Reference model on request acceptance, plus response / pin monitor
  always @(negedge clk) begin
    if (sync_req) begin
      exp_q.delete();
      acc_q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] <= seed(i);
      hold_v  <= 1'b0;
      last_mw <= 1'b0;
    end else if (!reset) begin
      hold_v  <= 1'b0;
      last_mw <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        if (req_we) begin
          ref_mem[req_addr] <= stored_val(req_wdata);
          exp_q.push_back({1'b1, 8'h00, VERIFY_ON && (stored_val(req_wdata) != req_wdata)});
          acc_q.push_back({req_addr, req_wdata});
        end else begin
          exp_q.push_back({1'b0, ref_mem[req_addr], 1'b0});
        end
      end
      if (hold_v && resp_valid) chk("resp_hold", {resp_we, resp_rdata, resp_err}, hold_val);
      hold_v   <= resp_valid && !resp_ready;
      hold_val <= {resp_we, resp_rdata, resp_err};
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) fail("resp_unexpected");
        else chk("resp", {resp_we, resp_rdata, resp_err}, exp_q.pop_front());
      end
      if (mem_write) begin
        if (last_mw) fail("mem_write_width");
        if (acc_q.size() == 0) fail("mem_write_unexpected");
        else chk("mem_pins", {mem_A, mem_WD}, acc_q.pop_front());
      end
      last_mw <= mem_write;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request (called just after a rising edge); t_acc = cyc before the accept edge
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d, output int t_acc);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    t_acc = -1;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        t_acc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!done) fail("req_accept_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) fail("drain_timeout");
  endtask

  task automatic lat_test(input logic [7:0] a, input logic [7:0] d, input int exp_r);
    int t0, tw, tr;
    send(1'b1, a, d, t0);
    tw = -1;
    tr = -1;
    for (int k = 0; k < 20 && tr < 0; k++) begin
      @(negedge clk);
      if (mem_write && tw < 0) tw = cyc;
      if (resp_valid && tr < 0) tr = cyc;
    end
    chk("store_write_lat", tw - t0, 2);
    chk("store_resp_lat", tr - t0, exp_r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t, n_hs, seen;
    int stamps [3];
    logic we_v;
    logic [7:0] a_v;

    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int t, n_hs, seen, found;
    int stamps [3];
    logic we_v;
    logic [7:0] a_v;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rr_mode = 1'b0; rr_fixed = 1'b0; stuck = 1'b0; sync_req = 1'b1;
    cycles(3);
    sync_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, resp_we, resp_rdata, resp_err}, 0);
    chk("rst_mem_pins", {mem_write, mem_A, mem_WD}, 0);
    chk("rst_busy", busy, 0);
    cycles(1);

    // Reset while a store is driving the write strobe
    send(1'b1, 8'h10, 8'h55, t);
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_write) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid_found_write", found, 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_write_drop", mem_write, 0);
    chk("rst_mid_resp_valid", resp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 sync_req = 1'b1;
    cycles(1);
    sync_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("rst_mid_no_resp", seen, 0);
    cycles(1);

    // Store/load latency and read-back
    rr_fixed = 1'b1;
    cycles(2);
    lat_test(8'h3C, 8'hA5, RESP_LAT);
    send(1'b0, 8'h3C, 8'h00, t);
    drain();

    // Top address store, then seeded address 0 load
    send(1'b1, 8'hFF, 8'h01, t);
    send(1'b0, 8'h00, 8'h00, t);
    drain();

    // Backpressure: one in RESP, FIFO full
    rr_fixed = 1'b0;
    cycles(2);
    send(1'b0, 8'h20, 8'h00, t);
    send(1'b0, 8'h21, 8'h00, t);
    send(1'b0, 8'h22, 8'h00, t);
    cycles(3);
    @(negedge clk);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_resp_valid", resp_valid, 1);
    chk("bp_busy", busy, 1);
    @(posedge clk);
    #1 rr_fixed = 1'b1;
    n_hs = 0;
    for (int k = 0; k < 30 && n_hs < 3; k++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        stamps[n_hs] = cyc;
        n_hs++;
      end
    end
    chk("bp_resp_count", n_hs, 3);
    if (n_hs == 3) begin
      chk("bp_gap1", stamps[1] - stamps[0], 2);
      chk("bp_gap2", stamps[2] - stamps[1], 2);
    end
    cycles(1);
    drain();

`ifdef WRITE_VERIFY_EN
    stuck = 1'b1;
    lat_test(8'h40, 8'h01, 4);
    send(1'b1, 8'h41, 8'h02, t);
    drain();
    stuck = 1'b0;
`endif

    // Random request mix with random response stalls
    rr_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      we_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a_v = 8'($urandom);
      else a_v = 8'($urandom_range(0, 15));
      send(we_v, a_v, 8'($urandom), t);
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    rr_mode = 1'b0;
    rr_fixed = 1'b1;
    drain();
    cycles(2);
    chk("final_resp_queue_empty", exp_q.size(), 0);
    chk("final_write_queue_empty", acc_q.size(), 0);
    chk("final_idle", {busy, req_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
